// File: rtl/brightness_pkg.sv
// Shared types, default geometry and lane saturation helper for the
// brightness-adjust sequencer.
package brightness_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int LANES_DEF  = 4;
  localparam int DEPTH_DEF  = 2100;
  localparam int ADDR_W_DEF = 12;
  localparam int OFF_W_DEF  = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WR,
    S_DONE
  } state_e;

  // Adds a signed offset to an unsigned pixel value and clamps the result
  // to the range of a pix_w-bit unsigned lane.
  function automatic int sat_add(input int pix, input int off, input int pix_w);
    int sum;
    int hi;
    sum = pix + off;
    hi  = (1 << pix_w) - 1;
    if (sum < 0) begin
      return 0;
    end
    if (sum > hi) begin
      return hi;
    end
    return sum;
  endfunction

endpackage

// File: rtl/brightness_ctrl_if.sv
// Control, source-read and destination-write signals of the brightness
// sequencer; master is the sequencer, slave is the surrounding system.
interface brightness_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 32,
  parameter int OFF_W  = 9
);

  logic                    start;
  logic                    abort;
  logic [ADDR_W:0]         num_words;
  logic signed [OFF_W-1:0] offset;
  logic                    busy;
  logic                    done;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
  logic [WORD_W-1:0]       rd_data;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [WORD_W-1:0]       wr_data;
  logic                    wr_ready;

  modport master (
    input  start, abort, num_words, offset, rd_data, wr_ready,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, abort, num_words, offset, rd_data, wr_ready,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/brightness_lane.sv
// One pixel lane: zero-extended pixel plus sign-extended offset, clamped
// to the unsigned lane range. Purely combinational.
module brightness_lane
  import brightness_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int OFF_W = OFF_W_DEF
) (
  input  logic [PIX_W-1:0]        pix_i,
  input  logic signed [OFF_W-1:0] off_i,
  output logic [PIX_W-1:0]        sum_o
);

  always_comb begin
    sum_o = PIX_W'(sat_add(int'(pix_i), int'(off_i), PIX_W));
  end

endmodule

// File: rtl/brightness_ctrl.sv
// Restartable, back-pressured brightness pass: read a word, adjust every
// lane with saturation, write it out, repeat for the latched word count.
//
// state  | meaning
// IDLE   | waiting for start; config latched on accept
// RD     | rd_en issued for the current index
// CALC   | source word arrives; adjusted word registered into wr_data
// WR     | wr_en held until wr_ready; advances index or finishes
// DONE   | one-cycle done pulse, then back to IDLE
module brightness_ctrl
  import brightness_pkg::*;
#(
  parameter int  PIX_W  = PIX_W_DEF,
  parameter int  LANES  = LANES_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  parameter int  ADDR_W = ADDR_W_DEF,
  parameter int  OFF_W  = OFF_W_DEF,
  localparam int WORD_W = PIX_W * LANES
) (
  input  logic              clk,
  input  logic              rst,
  brightness_ctrl_if.master bus
);

  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_N   = (ADDR_W+1)'(1);

  state_e                  state_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [ADDR_W:0]         nw_q;
  logic signed [OFF_W-1:0] off_q;

  logic                    busy_q;
  logic                    done_q;
  logic                    rd_en_q;
  logic                    wr_en_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [WORD_W-1:0]       wr_data_q;

  logic [WORD_W-1:0]       wr_data_d;
  logic [ADDR_W:0]         nw_d;
  logic [ADDR_W-1:0]       idx_d;
  logic                    last_word;

  always_comb begin
    nw_d      = (bus.num_words > DEPTH_N) ? DEPTH_N : bus.num_words;
    idx_d     = idx_q + ADDR_W'(1);
    last_word = ({1'b0, idx_q} == (nw_q - ONE_N));
  end

  // Lanes work on the live source word; only CALC registers the result.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    brightness_lane #(
      .PIX_W (PIX_W),
      .OFF_W (OFF_W)
    ) u_lane (
      .pix_i (bus.rd_data[k*PIX_W +: PIX_W]),
      .off_i (off_q),
      .sum_o (wr_data_d[k*PIX_W +: PIX_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      nw_q      <= '0;
      off_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      if ((state_q != S_IDLE) && bus.abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        wr_en_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.start) begin
              off_q  <= bus.offset;
              nw_q   <= nw_d;
              idx_q  <= '0;
              busy_q <= 1'b1;
              if (nw_d == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= S_RD;
                rd_en_q   <= 1'b1;
                rd_addr_q <= '0;
              end
            end
          end
          S_RD: begin
            state_q <= S_CALC;
          end
          S_CALC: begin
            wr_data_q <= wr_data_d;
            wr_addr_q <= idx_q;
            wr_en_q   <= 1'b1;
            state_q   <= S_WR;
          end
          S_WR: begin
            if (bus.wr_ready) begin
              wr_en_q <= 1'b0;
              if (last_word) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                idx_q     <= idx_d;
                rd_addr_q <= idx_d;
                rd_en_q   <= 1'b1;
                state_q   <= S_RD;
              end
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            wr_en_q <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_brightness_ctrl.sv
// Directed bench for brightness_ctrl: memory model on the read side,
// scoreboard of expected writes popped on every accepted write.
module tb_brightness_ctrl;

  localparam int PIX_W  = 8;
  localparam int LANES  = 4;
  localparam int DEPTH  = 2100;
  localparam int ADDR_W = 12;
  localparam int OFF_W  = 9;
  localparam int WORD_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [WORD_W-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  brightness_ctrl_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .OFF_W(OFF_W)) bus ();

  brightness_ctrl #(
    .PIX_W  (PIX_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .OFF_W  (OFF_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int                cyc = 0;
  int                t0 = 0;
  int                checks = 0;
  int                errors = 0;
  int                done_cnt = 0;
  int                done_cyc = -1;
  int                rd_cnt = 0;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [WORD_W-1:0] mem [DEPTH];
  exp_t              sb_q [$];
  exp_t              mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] model(input logic [WORD_W-1:0] w, input int off);
    logic [WORD_W-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      v = int'(w[k*PIX_W +: PIX_W]) + off;
      if (v < 0) v = 0;
      else if (v > 255) v = 255;
      r[k*PIX_W +: PIX_W] = v[7:0];
    end
    return r;
  endfunction

  // Monitor samples late in the low phase, after stimulus drives have settled.
  always begin
    @(negedge clk);
    #4;
    if (!rst) begin
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
      if (bus.rd_en) rd_cnt++;
      if (bus.wr_en && bus.wr_ready) begin
        wr_cnt++;
        last_wr_addr = bus.wr_addr;
        checks++;
        assert (sb_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed write at addr %0d, expected no write", bus.wr_addr);
        end
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check("wr_addr", 64'(bus.wr_addr), 64'(mon_e.a));
          check("wr_data", 64'(bus.wr_data), 64'(mon_e.d));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while ((cyc - t0) < c) tick();
  endtask

  task automatic start_pass(input int n, input int off);
    tick();
    bus.num_words = n[ADDR_W:0];
    bus.offset    = off[OFF_W-1:0];
    bus.start     = 1'b1;
    t0 = cyc;
    step_to(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cnt, input int budget);
    int n;
    n = 0;
    while (done_cnt < exp_cnt && n < budget) begin
      tick();
      n++;
    end
    check("done_within_budget", 64'(done_cnt), 64'(exp_cnt));
  endtask

  task automatic push_const(input int a, input logic [WORD_W-1:0] d);
    exp_t e;
    e.a = a[ADDR_W-1:0];
    e.d = d;
    sb_q.push_back(e);
  endtask

  task automatic push_model(input int n, input int off);
    for (int i = 0; i < n; i++) push_const(i, model(mem[i], off));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    64'(bus.busy),    64'(0));
    check({tag, "_done"},    64'(bus.done),    64'(0));
    check({tag, "_rd_en"},   64'(bus.rd_en),   64'(0));
    check({tag, "_wr_en"},   64'(bus.wr_en),   64'(0));
    check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'(0));
    check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'(0));
    check({tag, "_wr_data"}, 64'(bus.wr_data), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, d0, tmp;
    logic [WORD_W-1:0] exp_w;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.num_words = '0;
    bus.offset    = '0;
    bus.wr_ready  = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;

    // Basic pass, positive offset with saturation
    mem[0] = 32'h00010203; mem[1] = 32'h10FEFF7F; mem[2] = 32'hFFFFFFFF;
    push_const(0, 32'h03040506); push_const(1, 32'h13FFFF82); push_const(2, 32'hFFFFFFFF);
    w0 = wr_cnt; d0 = done_cnt;
    start_pass(3, 3);
    check("t1_busy_c1", 64'(bus.busy), 64'(1));
    check("t1_rd_en_c1", 64'(bus.rd_en), 64'(1));
    check("t1_rd_addr_c1", 64'(bus.rd_addr), 64'(0));
    wait_done(d0 + 1, 50);
    check("t1_done_cycle", 64'(done_cyc), 64'(10));
    check("t1_busy_after", 64'(bus.busy), 64'(0));
    check("t1_writes", 64'(wr_cnt - w0), 64'(3));

    // Negative offset, clamp at zero
    mem[0] = 32'h04050600; mem[1] = 32'h80818283;
    push_const(0, 32'h00000100); push_const(1, 32'h7B7C7D7E);
    w0 = wr_cnt; d0 = done_cnt;
    start_pass(2, -5);
    wait_done(d0 + 1, 50);
    check("t2_done_cycle", 64'(done_cyc), 64'(7));
    check("t2_writes", 64'(wr_cnt - w0), 64'(2));

    // Back-pressure: wr_ready low for four cycles on the first write
    mem[0] = 32'hA0B1C2D3; mem[1] = 32'h11223344;
    push_model(2, 16);
    exp_w = model(mem[0], 16);
    w0 = wr_cnt; d0 = done_cnt;
    bus.wr_ready = 1'b0;
    start_pass(2, 16);
    for (int c = 3; c <= 6; c++) begin
      step_to(c);
      check("t3_stall_wr_en", 64'(bus.wr_en), 64'(1));
      check("t3_stall_wr_addr", 64'(bus.wr_addr), 64'(0));
      check("t3_stall_wr_data", 64'(bus.wr_data), 64'(exp_w));
    end
    step_to(7);
    bus.wr_ready = 1'b1;
    wait_done(d0 + 1, 50);
    check("t3_done_cycle", 64'(done_cyc), 64'(11));
    check("t3_writes", 64'(wr_cnt - w0), 64'(2));

    // Abort in CALC of word 1, then a normal single-word pass
    for (int i = 0; i < 5; i++) mem[i] = $urandom;
    push_model(1, -20);
    w0 = wr_cnt; d0 = done_cnt; r0 = rd_cnt;
    start_pass(5, -20);
    step_to(5);
    bus.abort = 1'b1;
    step_to(6);
    bus.abort = 1'b0;
    check("t4_abort_busy", 64'(bus.busy), 64'(0));
    check("t4_abort_rd_en", 64'(bus.rd_en), 64'(0));
    check("t4_abort_wr_en", 64'(bus.wr_en), 64'(0));
    step_to(12);
    check("t4_abort_writes", 64'(wr_cnt - w0), 64'(1));
    check("t4_abort_reads", 64'(rd_cnt - r0), 64'(2));
    check("t4_abort_no_done", 64'(done_cnt - d0), 64'(0));
    check("t4_abort_sb_empty", 64'(sb_q.size()), 64'(0));
    push_model(1, 100);
    d0 = done_cnt;
    start_pass(1, 100);
    wait_done(d0 + 1, 20);
    check("t4_restart_done_cycle", 64'(done_cyc), 64'(4));

    // Zero-length pass
    w0 = wr_cnt; d0 = done_cnt; r0 = rd_cnt;
    start_pass(0, 7);
    check("t5_done_c1", 64'(bus.done), 64'(1));
    check("t5_busy_c1", 64'(bus.busy), 64'(1));
    step_to(2);
    check("t5_busy_c2", 64'(bus.busy), 64'(0));
    check("t5_done_c2", 64'(bus.done), 64'(0));
    step_to(4);
    check("t5_done_count", 64'(done_cnt - d0), 64'(1));
    check("t5_done_cycle", 64'(done_cyc), 64'(1));
    check("t5_no_reads", 64'(rd_cnt - r0), 64'(0));
    check("t5_no_writes", 64'(wr_cnt - w0), 64'(0));

    // Start and offset changes mid-pass, start in the done cycle
    for (int i = 0; i < 3; i++) mem[i] = $urandom;
    push_model(3, 20);
    w0 = wr_cnt; d0 = done_cnt; r0 = rd_cnt;
    start_pass(3, 20);
    step_to(2);
    tmp = -100;
    bus.offset    = tmp[OFF_W-1:0];
    bus.num_words = 13'd1;
    bus.start     = 1'b1;
    step_to(4);
    bus.start = 1'b0;
    step_to(10);
    check("t6_done_c10", 64'(bus.done), 64'(1));
    bus.num_words = 13'd2;
    bus.start     = 1'b1;
    step_to(11);
    bus.start = 1'b0;
    check("t6_busy_c11", 64'(bus.busy), 64'(0));
    step_to(13);
    check("t6_busy_c13", 64'(bus.busy), 64'(0));
    check("t6_reads", 64'(rd_cnt - r0), 64'(3));
    check("t6_writes", 64'(wr_cnt - w0), 64'(3));
    check("t6_done_count", 64'(done_cnt - d0), 64'(1));
    check("t6_done_cycle", 64'(done_cyc), 64'(10));

    // Asynchronous reset while stalled in WR
    mem[0] = 32'h5A5A5A5A;
    push_model(3, 5);
    bus.wr_ready = 1'b0;
    start_pass(3, 5);
    step_to(4);
    check("t7_pre_reset_wr_en", 64'(bus.wr_en), 64'(1));
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("t7_reset");
    sb_q.delete();
    tick();
    rst = 1'b0;
    bus.wr_ready = 1'b1;

    // Full-depth pass
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    push_model(DEPTH, -37);
    w0 = wr_cnt; d0 = done_cnt;
    start_pass(DEPTH, -37);
    wait_done(d0 + 1, 7000);
    check("t8_done_cycle", 64'(done_cyc), 64'(3 * DEPTH + 1));
    check("t8_last_addr", 64'(last_wr_addr), 64'(DEPTH - 1));
    check("t8_writes", 64'(wr_cnt - w0), 64'(DEPTH));
    check("t8_sb_empty", 64'(sb_q.size()), 64'(0));

    // Word count above DEPTH clamps to DEPTH
    push_model(DEPTH, 50);
    w0 = wr_cnt; d0 = done_cnt;
    start_pass(4000, 50);
    wait_done(d0 + 1, 7000);
    check("t9_done_cycle", 64'(done_cyc), 64'(3 * DEPTH + 1));
    check("t9_last_addr", 64'(last_wr_addr), 64'(DEPTH - 1));
    check("t9_writes", 64'(wr_cnt - w0), 64'(DEPTH));
    tick();
    tick();
    check("t9_sb_empty", 64'(sb_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
